// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - data/address width and decode-info width
//   - access size encodings carried in ld_st_info[3:2]
//   - bit positions of the fields inside ld_st_info
//   - FSM state encoding (2-bit)
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int XLEN             = 32;
    localparam int LD_ST_INFO_WIDTH = 5;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    localparam int LD_ST_LOAD     = 0;
    localparam int LD_ST_STORE    = 1;
    localparam int LD_ST_SIZE_LSB = 2;
    localparam int LD_ST_SIZE_MSB = 3;
    localparam int LD_ST_UNSIGNED = 4;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Request/grant/response data-memory port between the LSU and memory.
//   mem_req_o     request valid (held until mem_gnt_i)
//   mem_gnt_i     memory accepted the request
//   mem_we_o      1 = write
//   mem_addr_o    word-aligned address
//   mem_be_o      byte enables
//   mem_wdata_o   lane-aligned store data
//   mem_rvalid_i  response valid (read data or write ack)
//   mem_rdata_i   read word
// Modports: master = LSU side, slave = memory side.
// -----------------------------------------------------------------------------
interface lsu_if;
    import lsu_pkg::*;

    logic            mem_req_o;
    logic            mem_gnt_i;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane formatting for the LSU.
//   size       access size (B/H/W)
//   is_unsigned zero-extend loads instead of sign-extend
//   offset     address bits [1:0]
//   rs2        raw store data
//   rdata      raw read word from memory
//   be         byte enables for the access
//   wdata      store data replicated onto every lane
//   load_data  shifted and extended load result
//   misalign   access crosses its natural alignment
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misalign
);

    function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic uns);
        logic signed [7:0]      s;
        logic signed [XLEN-1:0] r;
        s = signed'(b);
        r = s;
        return uns ? {{(XLEN-8){1'b0}}, b} : r;
    endfunction

    function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic uns);
        logic signed [15:0]     s;
        logic signed [XLEN-1:0] r;
        s = signed'(h);
        r = s;
        return uns ? {{(XLEN-16){1'b0}}, h} : r;
    endfunction

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        be        = 4'hF;
        wdata     = rs2;
        load_data = shifted;
        misalign  = |offset;
        unique case (size)
            LSU_SIZE_B: begin
                be        = 4'b0001 << offset;
                wdata     = {4{rs2[7:0]}};
                load_data = ext_byte(shifted[7:0], is_unsigned);
                misalign  = 1'b0;
            end
            LSU_SIZE_H: begin
                be        = 4'b0011 << offset;
                wdata     = {2{rs2[15:0]}};
                load_data = ext_half(shifted[15:0], is_unsigned);
                misalign  = offset[0];
            end
            default: begin
                // Word, and the unused encoding 3 treated like a word.
                be        = 4'hF;
                wdata     = rs2;
                load_data = shifted;
                misalign  = |offset;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Multi-cycle load/store unit downstream of execute. One access at a time:
// IDLE -> REQ -> WAIT -> DONE, stalling the core until the access completes.
//   clk_i, rst_i         clock, asynchronous active-high reset
//   ld_st_info_i         [0] LOAD, [1] STORE, [3:2] SIZE, [4] UNSIGNED
//   ex_agu_mem_addr_i    effective address
//   rs2_rdata_i          store data
//   mem                  data-memory port (lsu_if.master)
//   lsu_rd_wdata_o       extended load result (held until next load)
//   lsu_done_o           one-cycle completion pulse
//   lsu_stall_o          combinational core stall
//   lsu_misalign_o       combinational misaligned-access flag
// -----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [LD_ST_INFO_WIDTH-1:0] ld_st_info_i,
    input  logic [XLEN-1:0]             ex_agu_mem_addr_i,
    input  logic [XLEN-1:0]             rs2_rdata_i,
    lsu_if.master                       mem,
    output logic [XLEN-1:0]             lsu_rd_wdata_o,
    output logic                        lsu_done_o,
    output logic                        lsu_stall_o,
    output logic                        lsu_misalign_o
);

    lsu_state_e state_q, state_d;

    logic            is_load, is_store, is_op, start;
    logic [XLEN-1:0] addr_q, wdata_q, rd_wdata_q;
    logic            we_q, uns_q;
    logic [1:0]      size_q;
    logic [3:0]      be_q;

    logic [1:0]      al_size, al_offset;
    logic            al_uns;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata, al_load;
    logic            al_mis;

    // LOAD wins when both decode bits are set.
    assign is_load  = ld_st_info_i[LD_ST_LOAD];
    assign is_store = ld_st_info_i[LD_ST_STORE] & ~is_load;
    assign is_op    = is_load | is_store;

    // The aligner sees the live decode in IDLE (store lanes, misalign) and the
    // captured access afterwards (load extension when the response arrives).
    always_comb begin
        al_size   = size_q;
        al_uns    = uns_q;
        al_offset = addr_q[1:0];
        if (state_q == LSU_IDLE) begin
            al_size   = ld_st_info_i[LD_ST_SIZE_MSB:LD_ST_SIZE_LSB];
            al_uns    = ld_st_info_i[LD_ST_UNSIGNED];
            al_offset = ex_agu_mem_addr_i[1:0];
        end
    end

    lsu_align u_align (
        .size        (al_size),
        .is_unsigned (al_uns),
        .offset      (al_offset),
        .rs2         (rs2_rdata_i),
        .rdata       (mem.mem_rdata_i),
        .be          (al_be),
        .wdata       (al_wdata),
        .load_data   (al_load),
        .misalign    (al_mis)
    );

    assign start = (state_q == LSU_IDLE) & is_op & ~al_mis;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LSU_IDLE: if (start)            state_d = LSU_REQ;
            LSU_REQ:  if (mem.mem_gnt_i)    state_d = LSU_WAIT;
            LSU_WAIT: if (mem.mem_rvalid_i) state_d = LSU_DONE;
            LSU_DONE:                       state_d = LSU_IDLE;
            default:                        state_d = LSU_IDLE;
        endcase
    end

    // Access capture at issue; load result capture on the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_wdata_q <= '0;
        end else begin
            if (start) begin
                addr_q  <= ex_agu_mem_addr_i;
                we_q    <= is_store;
                be_q    <= al_be;
                wdata_q <= al_wdata;
                size_q  <= al_size;
                uns_q   <= al_uns;
            end
            if ((state_q == LSU_WAIT) && mem.mem_rvalid_i && !we_q) begin
                rd_wdata_q <= al_load;
            end
        end
    end

    assign mem.mem_req_o   = (state_q == LSU_REQ);
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
    assign mem.mem_be_o    = be_q;
    assign mem.mem_wdata_o = wdata_q;

    assign lsu_rd_wdata_o  = rd_wdata_q;
    assign lsu_done_o      = (state_q == LSU_DONE);
    assign lsu_stall_o     = start | (state_q == LSU_REQ) | (state_q == LSU_WAIT);
    assign lsu_misalign_o  = (state_q == LSU_IDLE) & is_op & al_mis;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu
// Scoreboard bench for lsu: a driver issues accesses and pushes expected
// request fields and load results; a monitor pops them when the DUT raises
// mem_req_o or lsu_done_o. Expected values come from a byte-addressed memory
// model; a separate word-level responder plays the data memory.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ld_st_info;
    logic [31:0] ex_addr;
    logic [31:0] rs2_data;
    logic [31:0] rd_wdata;
    logic        done, stall, misalign;

    lsu_if mif ();

    lsu dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ld_st_info_i      (ld_st_info),
        .ex_agu_mem_addr_i (ex_addr),
        .rs2_rdata_i       (rs2_data),
        .mem               (mif.master),
        .lsu_rd_wdata_o    (rd_wdata),
        .lsu_done_o        (done),
        .lsu_stall_o       (stall),
        .lsu_misalign_o    (misalign)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed memory) ----------------
    logic [7:0]  mdl_mem [logic [31:0]];
    logic [31:0] mdl_rd;

    function automatic logic [7:0] mdl_byte(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input int n, input logic uns);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(mdl_byte(a + 32'(k))) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // ---------------- memory responder (word-level) ----------------
    logic [31:0] bus_mem [logic [29:0]];
    int          gnt_dly = 0, rv_dly = 0;
    int          g_cnt = 0, r_cnt = 0;
    logic        r_pending = 1'b0;
    logic [31:0] r_data;
    int          rv_seen = 0;

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        bus_mem[a[31:2]] = w;
        for (int k = 0; k < 4; k++) mdl_mem[{a[31:2], 2'b00} + 32'(k)] = w[8*k +: 8];
    endtask

    initial begin
        mif.mem_gnt_i    = 1'b0;
        mif.mem_rvalid_i = 1'b0;
        mif.mem_rdata_i  = 32'h0;
    end

    always @(negedge clk) begin
        logic [31:0] w;
        mif.mem_gnt_i    = 1'b0;
        mif.mem_rvalid_i = 1'b0;
        if (r_pending) begin
            if (r_cnt == rv_dly) begin
                mif.mem_rvalid_i = 1'b1;
                mif.mem_rdata_i  = r_data;
                r_pending        = 1'b0;
                rv_seen++;
            end else begin
                r_cnt++;
            end
        end else if (mif.mem_req_o) begin
            if (g_cnt == gnt_dly) begin
                mif.mem_gnt_i = 1'b1;
                g_cnt         = 0;
                w = bus_mem.exists(mif.mem_addr_o[31:2]) ? bus_mem[mif.mem_addr_o[31:2]] : 32'h0;
                if (mif.mem_we_o) begin
                    for (int k = 0; k < 4; k++)
                        if (mif.mem_be_o[k]) w[8*k +: 8] = mif.mem_wdata_o[8*k +: 8];
                    bus_mem[mif.mem_addr_o[31:2]] = w;
                    r_data = $urandom;
                end else begin
                    r_data = w;
                end
                r_pending = 1'b1;
                r_cnt     = 0;
            end else begin
                g_cnt++;
            end
        end
    end

    // ---------------- scoreboard queues and monitor ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cycles;
    } req_t;

    req_t        req_q [$];
    logic [31:0] done_q [$];

    logic        prev_req = 1'b0;
    req_t        cur;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_we;
    int          req_cycles = 0;
    logic        unstable = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (mif.mem_req_o && !prev_req) begin
                snap_addr  = mif.mem_addr_o;
                snap_we    = mif.mem_we_o;
                snap_be    = mif.mem_be_o;
                snap_wdata = mif.mem_wdata_o;
                req_cycles = 1;
                unstable   = 1'b0;
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 32'(mif.mem_req_o), 32'h0);
                end else begin
                    cur = req_q.pop_front();
                    chk("req_addr", mif.mem_addr_o, cur.addr);
                    chk("req_we", 32'(mif.mem_we_o), 32'(cur.we));
                    chk("req_be", 32'(mif.mem_be_o), 32'(cur.be));
                    if (cur.we) chk("req_wdata", mif.mem_wdata_o, cur.wdata);
                end
            end else if (mif.mem_req_o) begin
                req_cycles++;
                if (mif.mem_addr_o !== snap_addr || mif.mem_we_o !== snap_we ||
                    mif.mem_be_o !== snap_be || mif.mem_wdata_o !== snap_wdata)
                    unstable = 1'b1;
            end else if (prev_req) begin
                chk("req_stable", 32'(unstable), 32'h0);
                chk("req_cycles", 32'(req_cycles), 32'(cur.cycles));
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 32'(done), 32'h0);
                else chk("rd_wdata", rd_wdata, done_q.pop_front());
            end
            prev_req = mif.mem_req_o;
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [4:0] info, input logic [31:0] a, input logic [31:0] d,
                         input int gd, input int rvd);
        logic        ld, uns;
        int          n, cyc;
        logic        got, stall_bad;
        req_t        e;
        gnt_dly    = gd;
        rv_dly     = rvd;
        ld_st_info = info;
        ex_addr    = a;
        rs2_data   = d;
        ld         = info[0];
        uns        = info[4];
        n          = 1 << info[3:2];
        #1;
        if ((a % n) != 0) begin
            chk("misalign_flag", 32'(misalign), 32'h1);
            chk("misalign_stall", 32'(stall), 32'h0);
            chk("misalign_req", 32'(mif.mem_req_o), 32'h0);
            @(negedge clk);
            chk("misalign_noreq", 32'(mif.mem_req_o), 32'h0);
            ld_st_info = 5'h0;
            return;
        end
        chk("issue_misalign", 32'(misalign), 32'h0);
        chk("issue_stall", 32'(stall), 32'h1);
        e.addr   = {a[31:2], 2'b00};
        e.we     = !ld;
        e.be     = 4'((32'((1 << n) - 1)) << a[1:0]);
        e.wdata  = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
        e.cycles = gd + 1;
        req_q.push_back(e);
        if (ld) begin
            mdl_rd = mdl_load(a, n, uns);
        end else begin
            for (int k = 0; k < n; k++) mdl_mem[a + 32'(k)] = d[8*k +: 8];
        end
        done_q.push_back(mdl_rd);
        cyc = 0; got = 1'b0; stall_bad = 1'b0;
        while (cyc < 100 && !got) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            else if (!stall) stall_bad = 1'b1;
        end
        chk("done_latency", 32'(cyc), 32'(3 + gd + rvd));
        chk("stall_held", 32'(stall_bad), 32'h0);
        chk("stall_in_done", 32'(stall), 32'h0);
        ld_st_info = 5'h0;
        @(negedge clk);
        chk("done_single", 32'(done), 32'h0);
    endtask

    localparam logic [4:0] LB  = 5'b00001;
    localparam logic [4:0] LBU = 5'b10001;
    localparam logic [4:0] LH  = 5'b00101;
    localparam logic [4:0] LW  = 5'b01001;
    localparam logic [4:0] SH  = 5'b00110;
    localparam logic [4:0] SW  = 5'b01010;

    initial begin
        int rvs;
        rst        = 1'b1;
        ld_st_info = 5'h0;
        ex_addr    = 32'h0;
        rs2_data   = 32'h0;
        mdl_rd     = 32'h0;
        #1;
        chk("rst_req", 32'(mif.mem_req_o), 32'h0);
        chk("rst_we", 32'(mif.mem_we_o), 32'h0);
        chk("rst_addr", mif.mem_addr_o, 32'h0);
        chk("rst_be", 32'(mif.mem_be_o), 32'h0);
        chk("rst_wdata", mif.mem_wdata_o, 32'h0);
        chk("rst_rd", rd_wdata, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Aligned word store, minimum latency.
        do_op(SW, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0);

        // Byte loads, signed and unsigned, top lane.
        preload(32'h2000_0000, 32'h80FF_7F01);
        do_op(LB, 32'h2000_0003, 32'h0, 0, 0);
        chk("lb_value", rd_wdata, 32'hFFFF_FF80);
        do_op(LBU, 32'h2000_0003, 32'h0, 1, 0);
        chk("lbu_value", rd_wdata, 32'h0000_0080);

        // Halfword store and load at offset 2.
        do_op(SH, 32'h3000_0002, 32'h0000_1234, 0, 1);
        preload(32'h3000_0010, 32'hABCD_0000);
        do_op(LH, 32'h3000_0012, 32'h0, 0, 0);
        chk("lh_value", rd_wdata, 32'hFFFF_ABCD);

        // Misaligned word load.
        do_op(LW, 32'h3000_0002, 32'h0, 0, 0);

        // Grant withheld for 5 cycles.
        do_op(SW, 32'h3000_0020, 32'h0BAD_F00D, 5, 0);
        do_op(LW, 32'h3000_0020, 32'h0, 5, 2);
        chk("lw_value", rd_wdata, 32'h0BAD_F00D);

        // Reset while waiting for the response; response lands after release.
        preload(32'h5000_0000, 32'h1234_5678);
        gnt_dly    = 0;
        rv_dly     = 2;
        ld_st_info = LW;
        ex_addr    = 32'h5000_0000;
        req_q.push_back('{addr: 32'h5000_0000, we: 1'b0, be: 4'hF, wdata: 32'h0, cycles: 1});
        @(negedge clk);
        @(negedge clk);
        rvs        = rv_seen;
        rst        = 1'b1;
        ld_st_info = 5'h0;
        #1;
        chk("midrst_req", 32'(mif.mem_req_o), 32'h0);
        chk("midrst_stall", 32'(stall), 32'h0);
        chk("midrst_rd", rd_wdata, 32'h0);
        done_q.delete();
        mdl_rd = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("postrst_done", 32'(done), 32'h0);
            chk("postrst_rd", rd_wdata, 32'h0);
        end
        chk("late_rvalid_seen", 32'(rv_seen - rvs), 32'h1);

        // Randomized accesses in a small window so loads hit earlier stores.
        for (int i = 0; i < 80; i++) begin
            logic [4:0]  info;
            int          kind;
            kind    = $urandom_range(0, 9);
            info    = 5'h0;
            info[0] = (kind <= 4) || (kind == 9);
            info[1] = (kind >= 5);
            info[3:2] = 2'($urandom_range(0, 2));
            info[4] = 1'($urandom_range(0, 1));
            do_op(info, 32'h4000_0000 + 32'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("req_q_empty", 32'(req_q.size()), 32'h0);
        chk("done_q_empty", 32'(done_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Multi-cycle load/store unit directly downstream of the execute stage.
- Takes the execute-stage AGU address, rs2 store data and load/store decode info.
- Drives a request/grant/response data-memory port and returns load write-back data.
- Holds the single-cycle core via lsu_stall_o until the memory transaction completes.

Parameters:
- XLEN, 32, data and address width; the shared `XLEN macro is used.
- LD_ST_INFO_WIDTH, 5, width of ld_st_info_i; the shared `LD_ST_INFO_WIDTH macro is used.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ld_st_info_i  in  5  decode fields: [0] LOAD, [1] STORE, [3:2] SIZE (0=B, 1=H, 2=W), [4] UNSIGNED.
- ex_agu_mem_addr_i  in  32  effective address from execute.
- rs2_rdata_i  in  32  store data.
- mem_req_o  out  1  memory request valid.
- mem_gnt_i  in  1  memory accepted the request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-aligned store data.
- mem_rvalid_i  in  1  response valid; read data for loads, write ack for stores.
- mem_rdata_i  in  32  read word.
- lsu_rd_wdata_o  out  32  extended load result.
- lsu_done_o  out  1  one-cycle pulse when the access completes.
- lsu_stall_o  out  1  combinational; holds PC and register-file writes.
- lsu_misalign_o  out  1  combinational; misaligned access detected.

Behaviour:
- Reset (async, rst_i=1): state=IDLE; mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, lsu_rd_wdata_o and lsu_done_o all 0. Reset mid-transaction drops the access; late mem_rvalid_i after reset is ignored in IDLE.
- op = LOAD | STORE. LOAD and STORE both set is illegal; LOAD takes priority.
- Misaligned when H and addr[0]=1, or W and addr[1:0]!=0. In IDLE: lsu_misalign_o=1, no request, lsu_stall_o=0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, op and aligned: register address, we, be and wdata; go to REQ.
  - REQ: mem_req_o=1 with stable fields; on mem_gnt_i go to WAIT. The memory does not give grant and rvalid in the same cycle.
  - WAIT: mem_req_o=0; on mem_rvalid_i capture formatted load data into lsu_rd_wdata_o (stores leave it unchanged); go to DONE.
  - DONE: lsu_done_o=1 for exactly one cycle; go to IDLE unconditionally.
- lsu_stall_o = (IDLE & op & aligned) | REQ | WAIT. It is 0 in DONE, so the pipeline advances and the next instruction is sampled in IDLE.
- Minimum latency, gnt and rvalid each one cycle after their trigger: IDLE to DONE in 4 cycles, 3 stall cycles.
- Store formatting, with o = addr[1:0]:
  - B: be = 4'b0001<<o; wdata = byte replicated x4.
  - H: be = 4'b0011<<o; wdata = half replicated x2.
  - W: be = 4'hF; wdata = rs2.
- Load formatting: shift mem_rdata_i right by o*8, then sign-extend from bit 7/15 (B/H) unless UNSIGNED; W passes through.
- Grant stalled indefinitely: remain in REQ with all outputs stable. No timeout.

Decomposition:
- Shared defines file:
  - LSU_SIZE_B/H/W encodings.
  - ld_st_info bit indices LD_ST_LOAD, LD_ST_STORE, LD_ST_SIZE_LSB/MSB, LD_ST_UNSIGNED.
  - LSU FSM state encodings (2-bit).
- Sub-module lsu_align: purely combinational.
  - Inputs: size, unsigned, offset, rs2, rdata.
  - Outputs: be, wdata, load_data, misalign.
- lsu holds the FSM and registers.

Test Plan:
- Aligned word store: addr=0x1000_0004, rs2=0xDEAD_BEEF, gnt after 1 cycle, rvalid after 1 cycle -> mem_addr_o=0x1000_0004, be=4'hF, we=1, wdata=0xDEAD_BEEF; stall high 3 cycles; done pulse on the 4th cycle.
- LB, signed and unsigned: addr=0x...03, rdata=0x80FF_7F01 -> LB gives 0xFFFF_FF80; LBU gives 0x0000_0080; be=4'b1000 on the request.
- SH at offset 2: rs2=0x0000_1234 -> be=4'b1100, wdata=0x1234_1234; LH at offset 2 with rdata=0xABCD_0000 gives 0xFFFF_ABCD.
- Misaligned LW at addr=0x...02 -> lsu_misalign_o=1, mem_req_o stays 0, lsu_stall_o=0.
- Grant held low 5 cycles -> mem_req_o and all mem_* fields stable for 6 cycles; stall high throughout; single done pulse after rvalid.
- Reset asserted in WAIT, rvalid arriving 1 cycle after reset release -> state IDLE, lsu_done_o stays 0, lsu_rd_wdata_o=0.
